// File: rtl/product_accumulator_if.sv
// Handshake bundle between the 4-bit multiplier stage, the product
// accumulator and the consumer of frame sums.
//   master : the side that offers products and takes frame sums
//   slave  : the accumulator itself
interface product_accumulator_if #(
  parameter int PW = 8,
  parameter int AW = 12
);
  logic          in_valid;
  logic [PW-1:0] in_product;
  logic          in_ready;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready;
  logic          overflow;

  modport master (
    output in_valid,
    output in_product,
    output acc_ready,
    input  in_ready,
    input  acc_out,
    input  acc_valid,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  acc_ready,
    output in_ready,
    output acc_out,
    output acc_valid,
    output overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a frame of LEN unsigned PW-bit products into an AW-bit result.
// Products arrive one per cycle on a valid/ready handshake; the frame sum is
// presented on a second valid/ready handshake and held until taken.
// A sticky overflow flag reports any carry out of the accumulator in a frame.
// Build option: define PRODUCT_ACC_SATURATE_EN to clamp the sum at 2^AW-1 on
// overflow instead of wrapping modulo 2^AW.
module product_accumulator #(
  parameter int PW  = 8,
  parameter int AW  = 12,
  parameter int LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  product_accumulator_if.slave   bus
);

  // A one-bit counter is kept even for LEN=1 so the vector is never empty.
  localparam int             CW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] out_q, out_d;
  logic          ovf_q, ovf_d;

  logic          beat;
  logic [AW:0]   sum_ext;
  logic          ovf_now;
  logic [AW-1:0] sum_nxt;

  // Unsigned add with the carry out of bit AW-1 kept as the top bit.
  function automatic logic [AW:0] add_ext(input logic [AW-1:0] a,
                                          input logic [PW-1:0] p);
    return {1'b0, a} + {{(AW + 1 - PW){1'b0}}, p};
  endfunction

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once the frame has overflowed the sum is pinned at full scale; the
  // sticky flag keeps it there even when later products are zero.
  function automatic logic [AW-1:0] frame_sum(input logic [AW-1:0] s,
                                              input logic          ovf);
    return ovf ? {AW{1'b1}} : s;
  endfunction
`else
  // Wrapping build: the low AW bits are the sum modulo 2^AW.
  function automatic logic [AW-1:0] frame_sum(input logic [AW-1:0] s);
    return s;
  endfunction
`endif

  // Datapath for the beat currently offered; only used when it is accepted.
  always_comb begin
    beat    = bus.in_valid && (state_q == ACCUM);
    sum_ext = add_ext(acc_q, bus.in_product);
    ovf_now = ovf_q | sum_ext[AW];
`ifdef PRODUCT_ACC_SATURATE_EN
    sum_nxt = frame_sum(sum_ext[AW-1:0], ovf_now);
`else
    sum_nxt = frame_sum(sum_ext[AW-1:0]);
`endif
  end

  // Next-state logic: clear beats every handshake, then ACCUM/HOLD rules.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    out_d   = out_q;

    if (clear) begin
      // Abort: any beat this cycle and any pending result are dropped.
      // acc_out keeps its last value; only a new frame replaces it.
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (beat) begin
            acc_d = sum_nxt;
            ovf_d = ovf_now;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              out_d   = sum_nxt;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          // The flag stays with the held result and is cleared on hand-off.
          if (bus.acc_ready) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and datapath registers; reset also zeroes the visible result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  // Handshake outputs come straight from registered state.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.acc_valid = (state_q == HOLD);
  assign bus.acc_out   = out_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator stage that consumes 8-bit products from the sequential 4-bit multiplier stage and sums a fixed-length frame of `LEN` products into one wider result. It sits directly downstream of the multiplier in the multiply/MAC datapath. It accepts one product per cycle over a valid/ready handshake and presents the frame sum on a second valid/ready handshake. It flags arithmetic overflow per frame.

## Interface
- `PW`, default 8: product (input) width.
- `AW`, default 12: accumulator/result width; `AW >= PW` required.
- `LEN`, default 4: products per frame; `LEN >= 1`.
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `clear`, input, 1: synchronous frame abort/restart.
- `in_valid`, input, 1: product beat offered.
- `in_product`, input, PW: unsigned product.
- `in_ready`, output, 1: stage can take a beat.
- `acc_out`, output, AW: frame sum; stable while `acc_valid`.
- `acc_valid`, output, 1: frame sum available.
- `acc_ready`, input, 1: consumer takes the sum.
- `overflow`, output, 1: frame sum exceeded `2^AW-1`; valid with `acc_out`.

## Operation
- State machine has two states:
  - ACCUM: `in_ready=1`, `acc_valid=0`.
  - HOLD: `in_ready=0`, `acc_valid=1`.
- Beat accepted when `in_valid && in_ready`:
  - `acc <= acc + zero_extend(in_product)`.
  - Beat counter (0..LEN-1) increments.
- Frame completes on the accepted beat with counter `== LEN-1`:
  - `acc_out` takes the final sum.
  - Counter returns to 0.
  - State goes to HOLD.
- Arithmetic is unsigned. The sum wraps modulo `2^AW`.
- `overflow` is sticky within a frame. It sets on any carry out of bit `AW-1` and includes the completing beat.
- In HOLD, when `acc_ready=1`:
  - Next state is ACCUM.
  - `acc`, counter and `overflow` are cleared.
  - `acc_out` holds its last value until the next frame completes.
- Inputs are ignored in HOLD. `in_product` is a don't-care when `in_valid=0`.
- `clear=1` has priority over every handshake, in either state. On the next edge:
  - State becomes ACCUM.
  - `acc=0`, counter=0, `overflow=0`, `acc_valid=0`.
  - A beat presented in the same cycle is discarded.
  - A pending HOLD result is dropped.
- `rst_n=0` mid-frame has the same effect as `clear`, plus `acc_out=0`.
- Reset values: `in_ready=1`, `acc_valid=0`, `acc_out=0`, `overflow=0`, state ACCUM, counter 0.

## Timing
- `in_ready` and `acc_valid` are decoded from registered state only, with no combinational input-to-output path.
- Latency: `acc_valid` rises on the edge that accepts the last beat, so it is visible the following cycle.
- Throughput:
  - One beat per cycle in ACCUM.
  - Minimum one HOLD cycle per frame.
  - Back-to-back frames therefore take `LEN+1` cycles each when `acc_ready` is held high.
- HOLD persists indefinitely while `acc_ready=0`. `acc_out` and `overflow` stay stable during that time.
- `LEN=1`: every accepted beat completes a frame, alternating ACCUM/HOLD.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined: on overflow the sum clamps to `2^AW-1` and stays there for the rest of the frame. `overflow` is still set.
- Undefined: the sum wraps modulo `2^AW` as described above.
- Handshake, state machine and timing are identical in both builds.

## Test plan
- Reset/basic: `rst_n` low 2 cycles, then products 3, 5, 7, 9 on consecutive cycles (LEN=4, AW=12):
  - Outputs read 0/`in_ready=1` after reset.
  - `acc_out=24` and `acc_valid=1` in the cycle after the 4th beat.
  - `overflow=0`.
- Backpressure:
  - Complete a frame, then hold `acc_ready=0` for 5 cycles while driving `in_valid=1`. Required: `in_ready=0`, `acc_out` constant, no beats consumed.
  - Raise `acc_ready`. Required: ACCUM in the next cycle.
- Bubbles: beats 10, 20, 30, 40 with `in_valid` gaps of 0-3 cycles → `acc_out=100`.
- Overflow (AW=9): four beats of 225:
  - Without macro: `acc_out=388`, `overflow=1`.
  - With `PRODUCT_ACC_SATURATE_EN`: `acc_out=511`, `overflow=1`.
  - The next frame of 1, 1, 1, 1 gives 4 with `overflow=0`.
- Clear/reset mid-frame:
  - Two beats of 50, then `clear` together with a beat of 50, then 1, 2, 3, 4 → `acc_out=10`.
  - Repeat the sequence using `rst_n` in place of `clear` → same result.
- Back-to-back frames with `acc_ready` tied high: 8 beats of 1 fed whenever `in_ready=1` → two results of 4, spaced 5 cycles apart.
